mix_sar_agc_top: RTL
====================

Name: mix_sar_agc_top

Overview:
- Parametrised successor of the mixed-signal front-end top.
- Integrates, in one clocked block:
  - differential comparator decoding;
  - a SAR conversion FSM driving the capacitive DAC (v_in_ctrl / vref_ctrl);
  - offset-binary to two's-complement conversion with a valid strobe;
  - windowed peak-detect AGC driving a thermometer-coded VGA control bus.
- Sits between the analog macro (comparator, DAC, VGA) and the digital DSP chain.

Parameters:
- ADC_W, 8, SAR resolution in bits; width of vref_ctrl and adc_out_signed.
- SAMPLE_CYCLES, 2, clocks v_in_ctrl is held high per conversion (>=1).
- GAIN_MAX, 6, highest VGA gain code; vga_control_out width = GAIN_MAX.
- AGC_WIN, 16, conversions per AGC evaluation window (>=1).
- AGC_HI, 96, peak magnitude at or above which gain steps down.
- AGC_LO, 32, peak magnitude below which gain steps up (AGC_LO < AGC_HI).
- GAIN_W, $clog2(GAIN_MAX+1), derived gain code width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- start  in  1  conversion request; level-sensitive, held high = free-running.
- cmp_out_p  in  1  comparator positive output.
- cmp_out_n  in  1  comparator negative output.
- agc_en  in  1  1 = automatic gain, 0 = manual gain.
- gain_manual  in  GAIN_W  gain code used when agc_en=0; values above GAIN_MAX saturate to GAIN_MAX.
- v_in_ctrl  out  1  DAC input-sampling switch.
- vref_ctrl  out  ADC_W  DAC trial code.
- adc_out_signed  out  ADC_W  last result, two's complement.
- adc_valid  out  1  one-cycle pulse when adc_out_signed updates.
- busy  out  1  high while not in IDLE.
- vga_control_out  out  GAIN_MAX  thermometer code: bit k = (gain > k).
- gain_code  out  GAIN_W  current gain code.
- cmp_err_cnt  out  8  invalid-comparator event counter (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM returns to IDLE; all outputs 0; window counter and peak cleared.
  - gain_code = GAIN_MAX/2 (integer division); vga_control_out follows it.
  - Reset is effective mid-conversion: partial result is discarded and no adc_valid is emitted.
- Comparator decision:
  - cmp = cmp_out_p, sampled at the clk edge.
  - The pair (p,n) is invalid when p==n; an invalid pair resolves to cmp=0.
- FSM:
  - IDLE: if start, go to SAMPLE and load the sample counter; busy=0.
  - SAMPLE:
    - v_in_ctrl=1, vref_ctrl=0.
    - After SAMPLE_CYCLES clocks, go to CONVERT with bit index i=ADC_W-1 and trial=1<<(ADC_W-1).
  - CONVERT:
    - v_in_ctrl=0; vref_ctrl = trial, registered.
    - One clock per bit: at the edge, if cmp=1 keep bit i, else clear bit i.
    - If i>0: set bit i-1 and decrement i. If i==0: go to DONE.
  - DONE (one clock):
    - adc_out_signed = {~code[MSB], code[MSB-1:0]}; adc_valid=1.
    - Then SAMPLE if start, else IDLE.
- Latency: start high in IDLE -> adc_valid exactly 1+SAMPLE_CYCLES+ADC_W+1 clocks later. Default parameters: 12 clocks.
- Back-to-back: conversion period with start held high is SAMPLE_CYCLES+ADC_W+1 clocks.
- start deasserted mid-conversion: the current conversion completes.
- AGC:
  - On each adc_valid: mag = |adc_out_signed|, where the most-negative value maps to 2^(ADC_W-1), computed at ADC_W+1 bits.
  - peak = max(peak, mag).
  - On the AGC_WIN-th valid, evaluate using the peak including the current sample:
    - if peak >= AGC_HI and gain>0: gain-1;
    - else if peak < AGC_LO and gain<GAIN_MAX: gain+1;
    - else hold.
  - Then clear peak and window counter. Gain changes take effect the cycle after evaluation.
  - Gain is never driven below 0 or above GAIN_MAX.
- agc_en=0:
  - gain_code = saturated gain_manual, registered with 1 clock latency.
  - Window counter and peak held cleared.
  - On re-enable, AGC starts from the current manual gain with a fresh window.

Optional Feature:
- Macro: MIX_CMP_CHECK_EN.
- Defined:
  - cmp_err_cnt increments, saturating at 255, on every CONVERT clock where cmp_out_p==cmp_out_n.
  - Cleared only by reset.
- Undefined: cmp_err_cnt tied to 0; no counter logic.

Test Plan:
- Reset/idle: rst_n=0 for 3 clocks, defaults -> all outputs 0 except gain_code=3, vga_control_out=6'b000111.
- Single conversion:
  - Stimulus: start pulse; comparator model with analog code 8'hA5, cmp = (A5 >= trial).
  - Response: v_in_ctrl high 2 clocks; vref_ctrl sequence 80,C0,A0,B0,A8,A4,A6,A5.
  - Response: adc_valid at clock 12; adc_out_signed=8'h25.
- Free-run boundary codes:
  - Stimulus: start held, input codes 00 then FF.
  - Response: outputs 8'h80 then 8'h7F; valids spaced exactly 11 clocks apart.
- AGC step-down/saturation:
  - Stimulus: input code FF for 16 conversions.
  - Response: gain 3->2 after the 16th valid.
  - Continue for 64 more conversions -> gain reaches 0 and stays 0, vga_control_out=0.
- AGC step-up/hold and manual override:
  - Input code 0x90 (mag 16) for 4 windows -> gain 3->6 and holds at 6 (6'b111111).
  - Then mag 64 for a full window -> gain holds.
  - Then agc_en=0, gain_manual=7 -> gain_code=6 next clock.
- Reset mid-conversion and MIX_CMP_CHECK_EN:
  - rst_n=0 during CONVERT bit 4 -> no adc_valid; outputs back to reset values.
  - With macro defined, force p=n=1 for 3 CONVERT clocks -> cmp_err_cnt=3.

Source files
------------

// File: rtl/mix_sar_agc_top.sv
// Mixed-signal front-end: comparator decode, SAR conversion FSM, signed output and peak-detect AGC.
// Optional comparator-pair checking is enabled with `define MIX_CMP_CHECK_EN.
`timescale 1ns/1ps

module mix_sar_agc_top #(
    parameter int unsigned ADC_W         = 8,
    parameter int unsigned SAMPLE_CYCLES = 2,
    parameter int unsigned GAIN_MAX      = 6,
    parameter int unsigned AGC_WIN       = 16,
    parameter int unsigned AGC_HI        = 96,
    parameter int unsigned AGC_LO        = 32,
    localparam int unsigned GAIN_W       = $clog2(GAIN_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                cmp_out_p,
    input  logic                cmp_out_n,
    input  logic                agc_en,
    input  logic [GAIN_W-1:0]   gain_manual,
    output logic                v_in_ctrl,
    output logic [ADC_W-1:0]    vref_ctrl,
    output logic [ADC_W-1:0]    adc_out_signed,
    output logic                adc_valid,
    output logic                busy,
    output logic [GAIN_MAX-1:0] vga_control_out,
    output logic [GAIN_W-1:0]   gain_code,
    output logic [7:0]          cmp_err_cnt
);

    localparam int unsigned IDX_W  = (ADC_W > 1) ? $clog2(ADC_W) : 1;
    localparam int unsigned SCNT_W = $clog2(SAMPLE_CYCLES + 1);
    localparam int unsigned WIN_W  = $clog2(AGC_WIN + 1);
    localparam int unsigned MAG_W  = ADC_W + 1;

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

    state_t            state;
    logic [SCNT_W-1:0] scnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [ADC_W-1:0]  trial_next;
    logic              cmp;

    // An invalid pair (p==n) resolves to 0.
    assign cmp = cmp_out_p & ~cmp_out_n;

    // Next DAC code: resolve the current bit, then raise the next trial bit.
    always_comb begin
        trial_next = vref_ctrl;
        if (!cmp) trial_next[bit_idx] = 1'b0;
        if (bit_idx != '0) trial_next[bit_idx - 1'b1] = 1'b1;
    end

    // Conversion sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            scnt           <= '0;
            bit_idx        <= '0;
            v_in_ctrl      <= 1'b0;
            vref_ctrl      <= '0;
            adc_out_signed <= '0;
            adc_valid      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            adc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SAMPLE;
                        scnt      <= SCNT_W'(SAMPLE_CYCLES - 1);
                        v_in_ctrl <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SAMPLE: begin
                    if (scnt == '0) begin
                        state     <= CONVERT;
                        v_in_ctrl <= 1'b0;
                        bit_idx   <= IDX_W'(ADC_W - 1);
                        vref_ctrl <= {1'b1, {(ADC_W-1){1'b0}}};
                    end else begin
                        scnt <= scnt - 1'b1;
                    end
                end
                CONVERT: begin
                    vref_ctrl <= trial_next;
                    if (bit_idx == '0) state <= DONE;
                    else bit_idx <= bit_idx - 1'b1;
                end
                DONE: begin
                    adc_out_signed <= {~vref_ctrl[ADC_W-1], vref_ctrl[ADC_W-2:0]};
                    adc_valid      <= 1'b1;
                    vref_ctrl      <= '0;
                    if (start) begin
                        state     <= SAMPLE;
                        scnt      <= SCNT_W'(SAMPLE_CYCLES - 1);
                        v_in_ctrl <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [GAIN_MAX-1:0] therm(input logic [GAIN_W-1:0] g);
        logic [GAIN_MAX-1:0] t;
        for (int k = 0; k < int'(GAIN_MAX); k++) t[k] = (g > GAIN_W'(k));
        return t;
    endfunction

    logic [MAG_W-1:0]  ext, mag, peak, pk_now, peak_next;
    logic [WIN_W-1:0]  win_cnt, win_next;
    logic [GAIN_W-1:0] gain_next, gain_man_sat;

    // Magnitude at one extra bit so the most-negative code maps to 2^(ADC_W-1).
    assign ext          = {adc_out_signed[ADC_W-1], adc_out_signed};
    assign mag          = ext[ADC_W] ? (MAG_W'(0) - ext) : ext;
    assign pk_now       = (mag > peak) ? mag : peak;
    assign gain_man_sat = (gain_manual > GAIN_W'(GAIN_MAX)) ? GAIN_W'(GAIN_MAX) : gain_manual;

    always_comb begin
        gain_next = gain_code;
        peak_next = peak;
        win_next  = win_cnt;
        if (!agc_en) begin
            gain_next = gain_man_sat;
            peak_next = '0;
            win_next  = '0;
        end else if (adc_valid) begin
            if (win_cnt == WIN_W'(AGC_WIN - 1)) begin
                peak_next = '0;
                win_next  = '0;
                if (pk_now >= MAG_W'(AGC_HI) && gain_code != '0)
                    gain_next = gain_code - 1'b1;
                else if (pk_now < MAG_W'(AGC_LO) && gain_code < GAIN_W'(GAIN_MAX))
                    gain_next = gain_code + 1'b1;
            end else begin
                peak_next = pk_now;
                win_next  = win_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gain_code       <= GAIN_W'(GAIN_MAX / 2);
            vga_control_out <= therm(GAIN_W'(GAIN_MAX / 2));
            peak            <= '0;
            win_cnt         <= '0;
        end else begin
            gain_code       <= gain_next;
            vga_control_out <= therm(gain_next);
            peak            <= peak_next;
            win_cnt         <= win_next;
        end
    end

`ifdef MIX_CMP_CHECK_EN
    logic [7:0] err_cnt;

    // Saturating count of undecidable comparator pairs during bit trials.
    always_ff @(posedge clk) begin
        if (!rst_n) err_cnt <= '0;
        else if (state == CONVERT && (cmp_out_p == cmp_out_n) && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 1'b1;
    end

    assign cmp_err_cnt = err_cnt;
`else
    assign cmp_err_cnt = 8'd0;
`endif

endmodule
